// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : 640x480@60 Hz VGA raster timing generator. Produces
//                registered hsync/vsync/video_on, the current pixel
//                coordinates and line/frame start strobes, all aligned to
//                the same pixel with no relative skew.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
   parameter int   H_VIS  = 640,
   parameter int   H_FP   = 16,
   parameter int   H_SYNC = 96,
   parameter int   H_BP   = 48,
   parameter int   V_VIS  = 480,
   parameter int   V_FP   = 10,
   parameter int   V_SYNC = 2,
   parameter int   V_BP   = 33,
   parameter logic H_POL  = 1'b0,
   parameter logic V_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] c_H_MAX      = 10'(H_TOTAL - 1);
   localparam logic [9:0] c_V_MAX      = 10'(V_TOTAL - 1);
   localparam logic [9:0] c_H_VIS      = 10'(H_VIS);
   localparam logic [9:0] c_V_VIS      = 10'(V_VIS);
   localparam logic [9:0] c_HS_START   = 10'(H_VIS + H_FP);
   localparam logic [9:0] c_HS_END     = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] c_VS_START   = 10'(V_VIS + V_FP);
   localparam logic [9:0] c_VS_END     = 10'(V_VIS + V_FP + V_SYNC - 1);

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       video_on_q, video_on_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;

   // Next raster position: x wraps at end of line, y advances only on wrap.
   always_comb begin
      x_d = x_q + 10'd1;
      y_d = y_q;
      if (x_q == c_H_MAX) begin
         x_d = 10'd0;
         y_d = (y_q == c_V_MAX) ? 10'd0 : (y_q + 10'd1);
      end
   end

   // Decode timing flags from the next position so they register alongside it.
   always_comb begin
      hsync_d       = ((x_d >= c_HS_START) && (x_d <= c_HS_END)) ? H_POL : ~H_POL;
      vsync_d       = ((y_d >= c_VS_START) && (y_d <= c_VS_END)) ? V_POL : ~V_POL;
      video_on_d    = (x_d < c_H_VIS) && (y_d < c_V_VIS);
      line_start_d  = (x_d == 10'd0);
      frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
   end

   // Raster state; parked on the last blanking pixel while in reset so the
   // first enabled edge lands on (0,0). Strobes drop on any idle edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q           <= c_H_MAX;
         y_q           <= c_V_MAX;
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (ce) begin
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end else begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end
   end

   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Self-checking bench for vga_sync_gen. Three instances share
//                clk/rst/ce: full 640x480 timing, a reduced raster with
//                active-low syncs and the same reduced raster with
//                active-high syncs. Expected outputs come from a linear
//                pixel-index model of the raster.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ce  = 1'b0;

   logic       hs [3];
   logic       vs [3];
   logic       vo [3];
   logic       ls [3];
   logic       fs [3];
   logic [9:0] px [3];
   logic [9:0] py [3];

   int errors = 0;
   int checks = 0;

   // Model state: enabled edges since reset release, and whether the most
   // recent edge (out of reset) was enabled.
   int p       = 0;
   bit last_en = 1'b0;

   always #5 clk = ~clk;

   vga_sync_gen u_full (
      .clk(clk), .rst(rst), .ce(ce),
      .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]),
      .pixel_x(px[0]), .pixel_y(py[0]),
      .line_start(ls[0]), .frame_start(fs[0])
   );

   vga_sync_gen #(
      .H_VIS(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
      .V_VIS(12), .V_FP(3), .V_SYNC(2), .V_BP(4),
      .H_POL(1'b0), .V_POL(1'b0)
   ) u_small (
      .clk(clk), .rst(rst), .ce(ce),
      .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]),
      .pixel_x(px[1]), .pixel_y(py[1]),
      .line_start(ls[1]), .frame_start(fs[1])
   );

   vga_sync_gen #(
      .H_VIS(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
      .V_VIS(12), .V_FP(3), .V_SYNC(2), .V_BP(4),
      .H_POL(1'b1), .V_POL(1'b1)
   ) u_pol (
      .clk(clk), .rst(rst), .ce(ce),
      .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]),
      .pixel_x(px[2]), .pixel_y(py[2]),
      .line_start(ls[2]), .frame_start(fs[2])
   );

   // Reference: the k-th enabled edge shows linear pixel index (k-1) mod
   // (HT*VT); everything else is plain arithmetic on that index.
   function automatic logic [24:0] model(int k);
      int hv, hf, hw, hb, vv, vf, vw, vb, ht, vt, l, x, y;
      logic pol, h, v, vis, lsx, fsx;
      if (k == 0) begin
         hv = 640; hf = 16; hw = 96; hb = 48;
         vv = 480; vf = 10; vw = 2;  vb = 33;
         pol = 1'b0;
      end else begin
         hv = 20; hf = 4; hw = 6; hb = 5;
         vv = 12; vf = 3; vw = 2; vb = 4;
         pol = (k == 2);
      end
      ht = hv + hf + hw + hb;
      vt = vv + vf + vw + vb;
      if (p == 0)
         return {~pol, ~pol, 1'b0, 1'b0, 1'b0, 10'(ht - 1), 10'(vt - 1)};
      l   = (p - 1) % (ht * vt);
      x   = l % ht;
      y   = l / ht;
      h   = (x >= hv + hf && x < hv + hf + hw) ? pol : ~pol;
      v   = (y >= vv + vf && y < vv + vf + vw) ? pol : ~pol;
      vis = (x < hv) && (y < vv);
      lsx = last_en && (x == 0);
      fsx = last_en && (x == 0) && (y == 0);
      return {h, v, vis, lsx, fsx, 10'(x), 10'(y)};
   endfunction

   function automatic logic [24:0] observe(int k);
      return {hs[k], vs[k], vo[k], ls[k], fs[k], px[k], py[k]};
   endfunction

   // One clock edge with the given enable; outputs settle 1 ns later.
   task automatic tick(input bit en);
      ce = en;
      @(posedge clk);
      if (rst) begin
         if (en) p++;
         last_en = en;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      p = 0; last_en = 1'b0;
      repeat (3) tick(1'b1);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (observe(k) !== model(k)) begin
            errors++;
            $display("FAIL reset_inst%0d: got %h expected %h", k, observe(k), model(k));
         end
      end
      checks++;
      if (observe(0) !== {5'b11000, 10'd799, 10'd524}) begin
         errors++;
         $display("FAIL reset_literal: got %h expected %h", observe(0), {5'b11000, 10'd799, 10'd524});
      end
      checks++;
      if ({hs[2], vs[2]} !== 2'b00) begin
         errors++;
         $display("FAIL reset_pol_idle: got %b expected 00", {hs[2], vs[2]});
      end
   endtask

   task automatic test_first_edges();
      rst = 1'b1;
      tick(1'b1);
      checks++;
      if (observe(0) !== {5'b11111, 10'd0, 10'd0}) begin
         errors++;
         $display("FAIL first_edge: got %h expected %h", observe(0), {5'b11111, 10'd0, 10'd0});
      end
      tick(1'b1);
      checks++;
      if (observe(0) !== {5'b11100, 10'd1, 10'd0}) begin
         errors++;
         $display("FAIL second_edge: got %h expected %h", observe(0), {5'b11100, 10'd1, 10'd0});
      end
      for (int k = 1; k < 3; k++) begin
         checks++;
         if (observe(k) !== model(k)) begin
            errors++;
            $display("FAIL second_edge_inst%0d: got %h expected %h", k, observe(k), model(k));
         end
      end
   endtask

   task automatic test_line();
      int hs_low = 0, vis = 0, lsc = 0;
      for (int i = 0; i < 800; i++) begin
         tick(1'b1);
         if (!hs[0]) hs_low++;
         if (vo[0]) vis++;
         if (ls[0]) lsc++;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (observe(k) !== model(k)) begin
               errors++;
               if (errors < 20)
                  $display("FAIL line_inst%0d p=%0d: got %h expected %h", k, p, observe(k), model(k));
            end
         end
      end
      checks++;
      if (hs_low != 96) begin
         errors++;
         $display("FAIL line_hsync_width: got %0d expected 96", hs_low);
      end
      checks++;
      if (vis != 640) begin
         errors++;
         $display("FAIL line_visible: got %0d expected 640", vis);
      end
      checks++;
      if (lsc != 1) begin
         errors++;
         $display("FAIL line_start_count: got %0d expected 1", lsc);
      end
   endtask

   // Generic run: compares every instance each edge and measures small-raster
   // frame_start spacing, vsync-low and out-of-area video_on between the
   // first two frame starts.
   task automatic run_frames(input string name, input int n, input int mode,
                             input int exp_period);
      int t = 0, first = -1, second = -1, vs_low = 0, bad_vo = 0;
      bit en;
      for (int i = 0; i < n; i++) begin
         en = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 2) == 0) : ($urandom_range(0, 3) != 0);
         tick(en);
         t++;
         if (first >= 0 && second < 0) begin
            if (!vs[1]) vs_low++;
            if (vo[1] && py[1] >= 10'd12) bad_vo++;
         end
         if (fs[1]) begin
            if (first < 0) first = t;
            else if (second < 0) second = t;
         end
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (observe(k) !== model(k)) begin
               errors++;
               if (errors < 20)
                  $display("FAIL %s_inst%0d p=%0d: got %h expected %h", name, k, p, observe(k), model(k));
            end
         end
      end
      if (exp_period > 0) begin
         checks++;
         if (first < 0 || second < 0 || second - first != exp_period) begin
            errors++;
            $display("FAIL %s_frame_period: got %0d expected %0d", name, second - first, exp_period);
         end
         checks++;
         if (vs_low != 70 * (exp_period / 735)) begin
            errors++;
            $display("FAIL %s_vsync_low: got %0d expected %0d", name, vs_low, 70 * (exp_period / 735));
         end
         checks++;
         if (bad_vo != 0) begin
            errors++;
            $display("FAIL %s_video_blank: got %0d expected 0", name, bad_vo);
         end
      end
   endtask

   task automatic test_async_reset();
      int n;
      n = $urandom_range(50, 2000);
      repeat (n) tick(1'b1);
      #2;
      rst = 1'b0;
      p = 0; last_en = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (observe(k) !== model(k)) begin
            errors++;
            $display("FAIL async_reset_inst%0d: got %h expected %h", k, observe(k), model(k));
         end
      end
      tick(1'b1);
      rst = 1'b1;
      tick(1'b0);
      checks++;
      if (observe(0) !== {5'b11000, 10'd799, 10'd524}) begin
         errors++;
         $display("FAIL restart_idle: got %h expected %h", observe(0), {5'b11000, 10'd799, 10'd524});
      end
      tick(1'b1);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (observe(k) !== model(k) || fs[k] !== 1'b1) begin
            errors++;
            $display("FAIL restart_inst%0d: got %h expected %h", k, observe(k), model(k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_edges();
      test_line();
      run_frames("frame", 2 * 735 + 40, 0, 735);
      run_frames("ce_toggle", 4 * 735 + 40, 1, 1470);
      run_frames("random_ce", 3000, 2, 0);
      test_async_reset();
      run_frames("after_restart", 800, 2, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel-rate clock produced by the board clock divider.
- Outputs the sync pulses, the visible-area flag, the current pixel coordinates and frame/line start strobes.
- Downstream pixel/colour logic (snake board renderer) samples pixel_x/pixel_y and drives RGB while video_on is high.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
H_POL, 1'b0, hsync active level (0 = active-low)
V_POL, 1'b0, vsync active level (0 = active-low)

Ports:
clk  input  1  pixel-rate clock (25 MHz)
rst  input  1  asynchronous, active-low reset
ce  input  1  clock enable; raster advances only on edges where ce=1
hsync  output  1  horizontal sync, registered
vsync  output  1  vertical sync, registered
video_on  output  1  high when (pixel_x, pixel_y) is inside the visible area, registered
pixel_x  output  10  current horizontal position, 0..H_TOTAL-1
pixel_y  output  10  current vertical position, 0..V_TOTAL-1
line_start  output  1  one-clk strobe, high in the cycle pixel_x becomes 0
frame_start  output  1  one-clk strobe, high in the cycle (pixel_x, pixel_y) becomes (0,0)

Behaviour:
- Reset is rst, asynchronous, active-low; clock is clk. While rst=0:
  - pixel_x=H_TOTAL-1 (799), pixel_y=V_TOTAL-1 (524); the raster is parked on the last blanking pixel of a frame.
  - hsync=~H_POL (1), vsync=~V_POL (1), video_on=0, line_start=0, frame_start=0.
- Counters, on a rising edge with ce=1:
  - if pixel_x==H_TOTAL-1: pixel_x<=0; then pixel_y<=0 if pixel_y==V_TOTAL-1, else pixel_y+1.
  - else pixel_x<=pixel_x+1, pixel_y unchanged.
- On an edge with ce=0, every register holds its value, except line_start and frame_start, which are cleared to 0.
- Decoded outputs are registered together with the counters from the next counter values. They therefore describe exactly the pixel currently shown on pixel_x/pixel_y, with zero skew and no extra latency stage.
  - hsync = H_POL when H_VIS+H_FP <= x <= H_VIS+H_FP+H_SYNC-1 (656..751), else ~H_POL.
  - vsync = V_POL when V_VIS+V_FP <= y <= V_VIS+V_FP+V_SYNC-1 (490..491), else ~V_POL. vsync changes only at line boundaries (x wraps to 0).
  - video_on = (x < H_VIS) && (y < V_VIS).
  - line_start = 1 for one clk when the edge (ce=1) sets x to 0. frame_start = 1 for one clk when the edge sets (x,y) to (0,0).
- First edge with ce=1 after reset release moves to (0,0): video_on=1, line_start=1, frame_start=1.
- Counter widths are 10 bits. Values never exceed H_TOTAL-1 or V_TOTAL-1; no out-of-range states are reachable.
- Frame period is 800 x 525 = 420000 enabled cycles. Line period is 800 enabled cycles.
- Reset asserted mid-frame returns immediately (asynchronously) to the reset values above. Restart behaves as a fresh power-up: the next frame_start follows on the first enabled edge.

Test Plan:
- Hold rst=0 -> pixel_x=799, pixel_y=524, hsync=1, vsync=1, video_on=0, strobes 0. Release rst with ce=1; first edge -> (0,0), video_on=1, line_start=1, frame_start=1; next edge -> (1,0), both strobes 0.
- Run one line with ce=1 -> video_on high for x=0..639 and low for 640..799; hsync low exactly for x=656..751 (96 cycles); line_start at x=0 only; next line starts 800 cycles later with pixel_y=1.
- Run a full frame -> vsync low exactly for lines 490..491 (1600 enabled cycles); video_on never high for y>=480; after (799,524) the raster wraps to (0,0) with frame_start=1; frame_start period is 420000 cycles.
- Toggle ce (1,0,1,0...) -> counters advance only on ce=1 edges; a strobe set on a ce=1 edge lasts one clk and is cleared on the following ce=0 edge; frame period becomes 840000 clk.
- Assert rst at (300,200) with no clock edge -> outputs go to reset values immediately; release -> first enabled edge gives (0,0) and frame_start=1.
- Instance with H_POL=1, V_POL=1 -> hsync high only for x=656..751, vsync high only for y=490..491; idle level 0 in reset.
